// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian 32-bit words and writes them sequentially.
// Optional running checksum output enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          byte_last,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]   checksum,
`endif
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] buf_q, buf_d;
  logic        last_q, last_d;
  logic [AW:0] words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      words_q <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    words_d = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          bcnt_d  = '0;
          buf_d   = '0;
          last_d  = 1'b0;
          words_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (byte_valid) begin
          buf_d[8*bcnt_q +: 8] = byte_data;
          bcnt_d = bcnt_q + 2'd1;
          // A last flag on the final byte of a word is deferred to WRITE; anywhere else it aborts.
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
            last_d  = byte_last;
          end else if (byte_last) begin
            state_d = ERROR;
          end
        end
      end
      WRITE: begin
        words_d = words_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q + buf_q;
`endif
        if (last_q)
          state_d = DONE;
        else if (words_d == DEPTH_W)
          state_d = ERROR;
        else
          state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_ready   = (state_q == LOAD);
  assign imem_we      = (state_q == WRITE);
  assign busy         = (state_q == LOAD) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign imem_waddr   = words_q[AW-1:0];
  assign imem_wdata   = buf_q;
  assign words_loaded = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal loads, throttled valid, early last, overflow, reset abort.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, byte_valid, byte_last;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, busy, done, error;
  logic [6:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [7:0]  words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int compared   = 0;
  int mismatched = 0;

  imem_loader #(.DEPTH(128), .AW(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  logic [6:0]  wa [0:1023];
  logic [31:0] wd [0:1023];
  int          wr_n = 0;
  int          viol = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa[wr_n] = imem_waddr;
      wd[wr_n] = imem_wdata;
      wr_n++;
      if (prev_we) viol++;
      if (!busy || byte_ready) viol++;
    end
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int unsigned gap);
    logic got;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (byte_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (!got) chk("byte_accept_timeout", got === 1'b1, got, 1);
  endtask

  task automatic wait_end();
    logic fin;
    fin = 1'b0;
    for (int i = 0; i < 30 && !fin; i++) begin
      @(negedge clk);
      if (done || error) fin = 1'b1;
    end
    chk("end_timeout", fin === 1'b1, fin, 1);
    @(posedge clk); #1;
  endtask

  logic [7:0] prog [0:7];
  int base;

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h50; prog[7] = 8'h00;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_ready", byte_ready === 1'b0, byte_ready, 0);
    chk("rst_we", imem_we === 1'b0, imem_we, 0);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_done", done === 1'b0, done, 0);
    chk("rst_error", error === 1'b0, error, 0);
    chk("rst_words", words_loaded === 8'd0, words_loaded, 0);
    chk("rst_waddr", imem_waddr === 7'd0, imem_waddr, 0);
    chk("rst_wdata", imem_wdata === 32'd0, imem_wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    base = wr_n;
    pulse_start();
    chk("load_ready", byte_ready === 1'b1, byte_ready, 1);
    chk("load_busy", busy === 1'b1, busy, 1);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], (i == 7), 0);
      if (i == 4) pulse_start();
    end
    wait_end();
    chk("p1_nwr", (wr_n - base) == 2, wr_n - base, 2);
    chk("p1_a0", wa[base] === 7'd0, wa[base], 0);
    chk("p1_d0", wd[base] === 32'h00000013, wd[base], 32'h00000013);
    chk("p1_a1", wa[base+1] === 7'd1, wa[base+1], 1);
    chk("p1_d1", wd[base+1] === 32'h00500093, wd[base+1], 32'h00500093);
    chk("p1_done", done === 1'b1, done, 1);
    chk("p1_error", error === 1'b0, error, 0);
    chk("p1_words", words_loaded === 8'd2, words_loaded, 2);
    chk("p1_ready", byte_ready === 1'b0, byte_ready, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("p1_checksum", checksum === 32'h005000A6, checksum, 32'h005000A6);
`endif
    repeat (2) @(posedge clk); #1;
    chk("p1_done_hold", done === 1'b1, done, 1);

    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("prio_busy", busy === 1'b0, busy, 0);
    chk("prio_done", done === 1'b0, done, 0);
    chk("prio_words", words_loaded === 8'd0, words_loaded, 0);
    @(posedge clk); #1;
    chk("prio_idle", byte_ready === 1'b0, byte_ready, 0);

    base = wr_n;
    pulse_start();
    for (int i = 0; i < 8; i++)
      send_byte(prog[i], (i == 7), $urandom_range(0, 3));
    wait_end();
    chk("p2_nwr", (wr_n - base) == 2, wr_n - base, 2);
    chk("p2_a0", wa[base] === 7'd0, wa[base], 0);
    chk("p2_d0", wd[base] === 32'h00000013, wd[base], 32'h00000013);
    chk("p2_a1", wa[base+1] === 7'd1, wa[base+1], 1);
    chk("p2_d1", wd[base+1] === 32'h00500093, wd[base+1], 32'h00500093);
    chk("p2_done", done === 1'b1, done, 1);
    chk("p2_words", words_loaded === 8'd2, words_loaded, 2);
    chk("we_shape", viol == 0, viol, 0);

    base = wr_n;
    pulse_start();
    chk("restart_done_clr", done === 1'b0, done, 0);
    for (int i = 0; i < 6; i++)
      send_byte(prog[i], (i == 5), 0);
    wait_end();
    chk("p3_nwr", (wr_n - base) == 1, wr_n - base, 1);
    chk("p3_d0", wd[base] === 32'h00000013, wd[base], 32'h00000013);
    chk("p3_error", error === 1'b1, error, 1);
    chk("p3_done", done === 1'b0, done, 0);
    chk("p3_words", words_loaded === 8'd1, words_loaded, 1);

    base = wr_n;
    pulse_start();
    chk("restart_err_clr", error === 1'b0, error, 0);
    for (int i = 0; i < 512; i++)
      send_byte(8'(i), 1'b0, 0);
    wait_end();
    chk("p4_nwr", (wr_n - base) == 128, wr_n - base, 128);
    for (int w = 0; w < 128; w++) begin
      chk("p4_addr", wa[base+w] === 7'(w), wa[base+w], 7'(w));
      chk("p4_data", wd[base+w] === {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)},
          wd[base+w], {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    end
    chk("p4_error", error === 1'b1, error, 1);
    chk("p4_done", done === 1'b0, done, 0);
    chk("p4_ready", byte_ready === 1'b0, byte_ready, 0);
    chk("p4_words", words_loaded === 8'd128, words_loaded, 128);

    base = wr_n;
    pulse_start();
    for (int i = 0; i < 14; i++)
      send_byte(8'(8'hA0 + i), 1'b0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("p5_ready", byte_ready === 1'b0, byte_ready, 0);
    chk("p5_we", imem_we === 1'b0, imem_we, 0);
    chk("p5_busy", busy === 1'b0, busy, 0);
    chk("p5_done", done === 1'b0, done, 0);
    chk("p5_error", error === 1'b0, error, 0);
    chk("p5_words", words_loaded === 8'd0, words_loaded, 0);
    chk("p5_waddr", imem_waddr === 7'd0, imem_waddr, 0);
    chk("p5_wdata", imem_wdata === 32'd0, imem_wdata, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("p5_nwr", (wr_n - base) == 3, wr_n - base, 3);
    chk("p5_d2", wd[base+2] === 32'hABAAA9A8, wd[base+2], 32'hABAAA9A8);

    base = wr_n;
    pulse_start();
    send_byte(8'h37, 1'b0, 0);
    send_byte(8'h12, 1'b0, 1);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b1, 2);
    wait_end();
    chk("p6_nwr", (wr_n - base) == 1, wr_n - base, 1);
    chk("p6_a0", wa[base] === 7'd0, wa[base], 0);
    chk("p6_d0", wd[base] === 32'h00001237, wd[base], 32'h00001237);
    chk("p6_done", done === 1'b1, done, 1);
    chk("p6_words", words_loaded === 8'd1, words_loaded, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("p6_checksum", checksum === 32'h00001237, checksum, 32'h00001237);
`endif
    chk("we_shape_final", viol == 0, viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning the number of instruction-memory words that can be written.
REQ-002 SHALL have parameter AW, default 7, meaning the word-address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a program load.
REQ-006 SHALL have port byte_valid, input, 1 bit: the source presents a byte.
REQ-007 SHALL have port byte_data, input, 8 bits: the program byte, little-endian within each instruction.
REQ-008 SHALL have port byte_last, input, 1 bit: marks the final byte of the program; it is qualified by byte_valid.
REQ-009 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-010 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-011 SHALL have port imem_waddr, output, AW bits: the word index written, corresponding to pc[8:2] on the read side.
REQ-012 SHALL have port imem_wdata, output, 32 bits: the assembled instruction.
REQ-013 SHALL have port busy, output, 1 bit: high in LOAD or WRITE.
REQ-014 SHALL have port done, output, 1 bit: the load completed cleanly.
REQ-015 SHALL have port error, output, 1 bit: the load aborted.
REQ-016 SHALL have port words_loaded, output, AW+1 bits: the count of words written this load.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE and ERROR.
REQ-018 SHALL accept a byte only on a cycle with byte_valid && byte_ready; byte_ready SHALL be high only in LOAD.
REQ-019 SHALL place the k-th accepted byte of a word (k = 0..3) into bits [8k+7:8k] of the word buffer, using a 2-bit byte counter.
REQ-020 SHALL move LOAD -> WRITE when the byte accepted with k = 3; in WRITE it SHALL assert imem_we for exactly one cycle, with imem_waddr = words_loaded[AW-1:0] and imem_wdata = the assembled word.
REQ-021 SHALL increment words_loaded at the end of WRITE; WRITE then goes to DONE if that word's final byte had byte_last = 1, else to ERROR if words_loaded now equals DEPTH, else to LOAD.
REQ-022 SHALL go to ERROR if byte_last is accepted with k != 3; it SHALL NOT write the partial word, and words_loaded SHALL remain unchanged.
REQ-023 SHALL give one word a latency of 4 accepted bytes plus 1 WRITE cycle; peak throughput is 4 bytes per 5 cycles.
REQ-024 SHALL, on start in IDLE, DONE or ERROR, go to LOAD and clear words_loaded, the byte counter, done and error.
REQ-025 SHALL ignore start while busy = 1.
REQ-026 SHALL hold done and error as levels until the next start or reset; done and error SHALL never both be 1.
REQ-027 SHALL keep imem_we at 0 in every state other than WRITE.

Reset
REQ-028 SHALL, when reset is high at a clock edge, go to IDLE and set byte_ready, imem_we, busy, done, error and words_loaded to 0, and imem_waddr and imem_wdata to 0.
REQ-029 SHALL, on reset during LOAD or WRITE, abort with no further write and discard any partially assembled word.
REQ-030 SHALL give reset priority over start when both are asserted in the same cycle.

Configuration
REQ-031 SHALL, when macro IMEM_LOADER_CHECKSUM_EN is defined, add output checksum (32 bits): the modulo-2^32 sum of all imem_wdata values written this load, cleared to 0 on start and on reset, and updated in the same edge that ends WRITE.
REQ-032 SHALL, when IMEM_LOADER_CHECKSUM_EN is undefined, omit the checksum port and its logic, with all other behaviour identical.

Verification
REQ-033 SHALL verify: start, then bytes 13 00 00 00 / 93 00 50 00 with last on the 8th byte -> writes [0]=00000013 and [1]=00500093; done = 1; words_loaded = 2.
REQ-034 SHALL verify: byte_valid toggled randomly against the same stream -> identical writes; imem_we pulses only in WRITE, each exactly 1 cycle.
REQ-035 SHALL verify: last on the 6th byte -> exactly one write, error = 1, done = 0, words_loaded = 1.
REQ-036 SHALL verify: 512 bytes without last -> 128 writes (addresses 0..127), then error = 1 and byte_ready = 0.
REQ-037 SHALL verify: reset asserted after the 2nd byte of word 3 -> IDLE, no 4th write, all outputs 0; a subsequent start reloads from address 0.
REQ-038 SHALL verify, with IMEM_LOADER_CHECKSUM_EN defined: the REQ-033 stream -> checksum = 005000A6.
